config_write_scheduler: RTL and testbench

Sits between the spi block and the synth register sinks: the sine-table SPRAM and the voice-operator config RAMs in phase accumulator, modulator and envelope attenuator. Edge-detects SPI register writes, decodes the 16-bit register number, and buffers writes in a FIFO. Each write issues at a pipeline-safe slot: a voice-operator write lands only just after its target voice-op has left stage 0, so a config update never tears mid-evaluation.

---
 rtl/config_write_scheduler_pkg.sv | 50 +++++
 rtl/config_write_scheduler_fifo.sv | 54 +++++
 rtl/config_write_scheduler.sv | 129 ++++++++++++
 tb/tb_config_write_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_write_scheduler_pkg.sv
// rtl/config_write_scheduler_pkg.sv - shared types and register-number layout for the config write scheduler
package config_write_scheduler_pkg;

    localparam int REG_VALID_BIT  = 15;
    localparam int REG_SELECT_BIT = 14;
    localparam int REG_PARAM_MSB  = 13;
    localparam int REG_PARAM_LSB  = 8;
    localparam int REG_ADDR_MSB   = 7;
    localparam int REG_ADDR_LSB   = 0;

    localparam int VOICE_OP_ID_BITS = 8;
    typedef logic [VOICE_OP_ID_BITS-1:0] VOICE_OPERATOR_ID;

    localparam logic [5:0] PARAM_PHASE_STEP    = 6'h00;
    localparam logic [5:0] PARAM_ALGORITHM     = 6'h01;
    localparam logic [5:0] PARAM_ENV_ATTACK    = 6'h02;
    localparam logic [5:0] PARAM_ENV_DECAY     = 6'h03;
    localparam logic [5:0] PARAM_ENV_SUSTAIN   = 6'h04;
    localparam logic [5:0] PARAM_ENV_RELEASE   = 6'h05;
    localparam logic [5:0] PARAM_ENV_LEVEL     = 6'h06;
    localparam logic [5:0] PARAM_FEEDBACK      = 6'h07;
    localparam logic [5:0] PARAM_NOTE_ON_LOW   = 6'h10;
    localparam logic [5:0] PARAM_NOTE_ON_HIGH  = 6'h11;
    localparam logic [5:0] PARAM_LED           = 6'h12;

    typedef enum logic {
        STATE_IDLE,
        STATE_SCHEDULE
    } scheduleState_t;

    typedef struct packed {
        logic        isSine;
        logic [5:0]  param;
        logic [13:0] addr;
        logic [15:0] data;
    } writeEntry_t;

    localparam int WRITE_ENTRY_BITS = $bits(writeEntry_t);

    // Sine writes carry a 14-bit table address; voice-op writes carry the id in the low byte.
    function automatic writeEntry_t decodeWrite(input logic [14:0] number, input logic [15:0] value);
        writeEntry_t entry;
        entry.isSine = number[REG_SELECT_BIT];
        entry.param  = number[REG_PARAM_MSB:REG_PARAM_LSB];
        entry.addr   = entry.isSine ? number[13:0] : {6'b0, number[REG_ADDR_MSB:REG_ADDR_LSB]};
        entry.data   = value;
        return entry;
    endfunction

endpackage

// File: rtl/config_write_scheduler_fifo.sv
// rtl/config_write_scheduler_fifo.sv - first-word-fall-through FIFO holding decoded writes until they issue
module config_write_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 37
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset_n,
    input  logic                       i_Push,
    input  logic [WIDTH-1:0]           i_PushData,
    input  logic                       i_Pop,
    output logic [WIDTH-1:0]           o_HeadData,
    output logic                       o_Full,
    output logic                       o_Empty,
    output logic [$clog2(DEPTH):0]     o_Count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    logic [WIDTH-1:0]    storage [DEPTH];
    logic [PTR_BITS-1:0] readPtr;
    logic [PTR_BITS-1:0] writePtr;
    logic [PTR_BITS:0]   count;
    logic                doPush;
    logic                doPop;

    assign o_Full     = (count == FULL_COUNT);
    assign o_Empty    = (count == '0);
    assign o_Count    = count;
    assign o_HeadData = storage[readPtr];
    assign doPush     = i_Push && !o_Full;
    assign doPop      = i_Pop && !o_Empty;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            readPtr  <= '0;
            writePtr <= '0;
            count    <= '0;
        end else begin
            if (doPush) writePtr <= writePtr + 1'b1;
            if (doPop)  readPtr  <= readPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (doPush) storage[writePtr] <= i_PushData;
    end

endmodule

// File: rtl/config_write_scheduler.sv
// rtl/config_write_scheduler.sv - buffers SPI register writes and issues them into pipeline-safe slots
module config_write_scheduler
    import config_write_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int VOICE_OP_BITS = 8
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset_n,
    input  logic                     i_WriteStrobe,
    input  logic [15:0]              i_WriteNumber,
    input  logic [15:0]              i_WriteValue,
    input  logic [VOICE_OP_BITS-1:0] i_VoiceOperator,
    input  logic                     i_ClearErrors,
    output logic                     o_SineTableWriteEnable,
    output logic [13:0]              o_SineTableWriteAddress,
    output logic                     o_VoiceOpWriteEnable,
    output logic [5:0]               o_VoiceOpParameter,
    output logic [VOICE_OP_BITS-1:0] o_VoiceOpAddress,
    output logic [15:0]              o_WriteData,
    output logic                     o_Busy,
    output logic [1:0]               o_Error
);

    localparam int COUNT_BITS = $clog2(FIFO_DEPTH) + 1;
    localparam logic [COUNT_BITS-1:0] ONE_ENTRY = COUNT_BITS'(1);

    logic                  strobeLast;
    logic                  writeEdge;
    logic                  numberValid;
    writeEntry_t           incoming;
    writeEntry_t           head;
    logic [WRITE_ENTRY_BITS-1:0] headBits;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [COUNT_BITS-1:0] fifoCount;
    logic                  pushReq;
    logic                  headReady;
    logic                  issue;
    logic [1:0]            newError;
    scheduleState_t        state;
    scheduleState_t        stateNext;

    assign writeEdge   = i_WriteStrobe && !strobeLast;
    assign numberValid = i_WriteNumber[REG_VALID_BIT];
    assign incoming    = decodeWrite(i_WriteNumber[14:0], i_WriteValue);
    assign pushReq     = writeEdge && numberValid && !fifoFull;
    assign head        = writeEntry_t'(headBits);

    // Overflow is judged on occupancy before any same-cycle pop.
    assign newError = {writeEdge && !numberValid, writeEdge && numberValid && fifoFull};

    config_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WRITE_ENTRY_BITS)
    ) u_fifo (
        .i_Clock    (i_Clock),
        .i_Reset_n  (i_Reset_n),
        .i_Push     (pushReq),
        .i_PushData (incoming),
        .i_Pop      (issue),
        .o_HeadData (headBits),
        .o_Full     (fifoFull),
        .o_Empty    (fifoEmpty),
        .o_Count    (fifoCount)
    );

    assign headReady = !fifoEmpty &&
                       (head.isSine || (head.addr[VOICE_OP_BITS-1:0] == i_VoiceOperator));

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state      <= STATE_IDLE;
            strobeLast <= 1'b0;
        end else begin
            state      <= stateNext;
            strobeLast <= i_WriteStrobe;
        end
    end

    // IDLE evaluates a freshly arrived head at once so a sine write reaches its sink two cycles after the edge.
    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        case (state)
            STATE_IDLE: begin
                if (!fifoEmpty) begin
                    issue     = headReady;
                    stateNext = (headReady && fifoCount == ONE_ENTRY) ? STATE_IDLE : STATE_SCHEDULE;
                end
            end
            STATE_SCHEDULE: begin
                issue = headReady;
                if (fifoEmpty || (headReady && fifoCount == ONE_ENTRY)) stateNext = STATE_IDLE;
            end
            default: stateNext = STATE_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_SineTableWriteEnable  <= 1'b0;
            o_SineTableWriteAddress <= '0;
            o_VoiceOpWriteEnable    <= 1'b0;
            o_VoiceOpParameter      <= '0;
            o_VoiceOpAddress        <= '0;
            o_WriteData             <= '0;
            o_Error                 <= '0;
        end else begin
            o_SineTableWriteEnable <= 1'b0;
            o_VoiceOpWriteEnable   <= 1'b0;
            o_Error                <= (i_ClearErrors ? 2'b00 : o_Error) | newError;
            if (issue) begin
                o_WriteData <= head.data;
                if (head.isSine) begin
                    o_SineTableWriteEnable  <= 1'b1;
                    o_SineTableWriteAddress <= head.addr;
                end else begin
                    o_VoiceOpWriteEnable <= 1'b1;
                    o_VoiceOpParameter   <= head.param;
                    o_VoiceOpAddress     <= head.addr[VOICE_OP_BITS-1:0];
                end
            end
        end
    end

    assign o_Busy = !fifoEmpty || (state != STATE_IDLE);

endmodule

// File: tb/tb_config_write_scheduler.sv
// tb/tb_config_write_scheduler.sv - directed bench with a queue-level model of the config write scheduler
module tb_config_write_scheduler;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        strobe = 1'b0;
    logic [15:0] num = '0;
    logic [15:0] val = '0;
    logic [7:0]  vo = '0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    int          cyc = 0;

    logic        sineEn;
    logic [13:0] sineAddr;
    logic        voEn;
    logic [5:0]  voParam;
    logic [7:0]  voAddr;
    logic [15:0] wData;
    logic        busy;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (run) vo <= vo + 8'd1;
    end

    config_write_scheduler #(.FIFO_DEPTH(DEPTH), .VOICE_OP_BITS(8)) dut (
        .i_Clock                 (clk),
        .i_Reset_n               (rstN),
        .i_WriteStrobe           (strobe),
        .i_WriteNumber           (num),
        .i_WriteValue            (val),
        .i_VoiceOperator         (vo),
        .i_ClearErrors           (clr),
        .o_SineTableWriteEnable  (sineEn),
        .o_SineTableWriteAddress (sineAddr),
        .o_VoiceOpWriteEnable    (voEn),
        .o_VoiceOpParameter      (voParam),
        .o_VoiceOpAddress        (voAddr),
        .o_WriteData             (wData),
        .o_Busy                  (busy),
        .o_Error                 (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: a queue of pending writes; each clock the head leaves if it is a sine write or its id is entering stage 0.
    typedef struct {
        bit isSine;
        int param;
        int addr;
        int data;
    } mwrite_t;

    mwrite_t     mq[$];
    mwrite_t     mh;
    bit          mLast = 0;
    bit          mFull;
    logic [1:0]  mNewErr;
    logic        eSineEn = 0;
    logic [13:0] eSineAddr = '0;
    logic        eVoEn = 0;
    logic [5:0]  eParam = '0;
    logic [7:0]  eVoAddr = '0;
    logic [15:0] eData = '0;
    logic        eBusy = 0;
    logic [1:0]  eErr = '0;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mq.delete();
            mLast = 0;
            eSineEn = 0; eSineAddr = '0; eVoEn = 0; eParam = '0;
            eVoAddr = '0; eData = '0; eBusy = 0; eErr = '0;
        end else begin
            mFull = (mq.size() == DEPTH);
            eSineEn = 0;
            eVoEn = 0;
            if (mq.size() > 0) begin
                mh = mq[0];
                if (mh.isSine || mh.addr == int'(vo)) begin
                    eData = mh.data[15:0];
                    if (mh.isSine) begin
                        eSineEn = 1;
                        eSineAddr = mh.addr[13:0];
                    end else begin
                        eVoEn = 1;
                        eParam = mh.param[5:0];
                        eVoAddr = mh.addr[7:0];
                    end
                    void'(mq.pop_front());
                end
            end
            mNewErr = 2'b00;
            if (strobe && !mLast) begin
                if (!num[15]) mNewErr[1] = 1'b1;
                else if (mFull) mNewErr[0] = 1'b1;
                else begin
                    mh.isSine = num[14];
                    mh.param = int'(num[13:8]);
                    mh.addr = num[14] ? int'(num[13:0]) : int'(num[7:0]);
                    mh.data = int'(val);
                    mq.push_back(mh);
                end
            end
            eErr = (clr ? 2'b00 : eErr) | mNewErr;
            mLast = strobe;
            eBusy = (mq.size() != 0);
        end
    end

    always @(negedge clk) begin
        check("m_sine_en", sineEn, eSineEn);
        check("m_voice_en", voEn, eVoEn);
        check("m_data", wData, eData);
        check("m_sine_addr", sineAddr, eSineAddr);
        check("m_param", voParam, eParam);
        check("m_voice_addr", voAddr, eVoAddr);
        check("m_busy", busy, eBusy);
        check("m_error", err, eErr);
    end

    task automatic pulse(input logic [15:0] n, input logic [15:0] v);
        @(negedge clk);
        num = n; val = v; strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic waitVo(input logic [7:0] target);
        int n;
        n = 0;
        @(negedge clk);
        while (vo !== target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_vo", vo, target);
    endtask

    int cnt;
    int got;
    int lastCyc;
    int voCyc;
    int sineCyc;
    logic [7:0] seenVo;

    initial begin
        // 1: reset held under random inputs, then reset while a write is waiting
        run = 1'b1;
        repeat (20) begin
            @(negedge clk);
            strobe = 1'($urandom); num = 16'($urandom); val = 16'($urandom); clr = 1'($urandom);
        end
        check("t1_sine_en", sineEn, 0);
        check("t1_voice_en", voEn, 0);
        check("t1_data", wData, 0);
        check("t1_busy", busy, 0);
        check("t1_error", err, 0);
        strobe = 1'b0; clr = 1'b0;
        @(negedge clk); #2 rstN = 1'b1;
        pulse(16'hC00A, 16'hAAAA);
        repeat (4) @(negedge clk);
        waitVo(8'h50);
        pulse(16'h8040, 16'h1111);
        repeat (5) @(negedge clk);
        check("t1_busy_wait", busy, 1);
        #2 rstN = 1'b0;
        #1;
        check("t1_rst_data", wData, 0);
        check("t1_rst_addr", sineAddr, 0);
        check("t1_rst_busy", busy, 0);
        @(negedge clk); #2 rstN = 1'b1;
        cnt = 0;
        repeat (600) begin
            @(negedge clk);
            cnt += int'(voEn) + int'(sineEn);
        end
        check("t1_no_late_write", cnt, 0);

        // 2: sine write latency
        @(negedge clk);
        num = 16'hC123; val = 16'hBEEF; strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        check("t2_en_n1", sineEn, 0);
        @(negedge clk);
        check("t2_en_n2", sineEn, 1);
        check("t2_addr", sineAddr, 14'h0123);
        check("t2_data", wData, 16'hBEEF);
        @(negedge clk);
        check("t2_en_n3", sineEn, 0);
        check("t2_addr_hold", sineAddr, 14'h0123);

        // 3: voice-op write waits for its slot on the next wrap
        waitVo(8'h10);
        num = 16'h8205; val = 16'h1234; strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        got = 0; seenVo = '0;
        repeat (300) begin
            @(negedge clk);
            if (voEn) begin
                got++;
                seenVo = vo;
                check("t3_param", voParam, 6'h02);
                check("t3_addr", voAddr, 8'h05);
                check("t3_data", wData, 16'h1234);
            end
        end
        check("t3_count", got, 1);
        check("t3_slot", seenVo, 8'h06);

        // 4: frozen counter, nine writes, overflow then eight ordered frames
        waitVo(8'h00);
        run = 1'b0;
        for (int i = 0; i < 9; i++) pulse(16'h8080, 16'h4000 + 16'(i));
        @(negedge clk);
        check("t4_overflow", err, 2'b01);
        run = 1'b1;
        got = 0; lastCyc = 0;
        repeat (8 * 256 + 300) begin
            @(negedge clk);
            if (voEn) begin
                check("t4_order", wData, 16'h4000 + 16'(got));
                check("t4_slot", vo, 8'h81);
                if (got > 0) check("t4_frame", cyc - lastCyc, 256);
                lastCyc = cyc;
                got++;
            end
        end
        check("t4_count", got, 8);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;

        // 5: invalid register number and error clearing
        pulse(16'h0100, 16'h5555);
        check("t5_invalid", err, 2'b10);
        repeat (3) @(negedge clk);
        check("t5_no_write", busy, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t5_cleared", err, 2'b00);
        num = 16'h0100; strobe = 1'b1; clr = 1'b1;
        @(negedge clk);
        strobe = 1'b0; clr = 1'b0;
        check("t5_clear_vs_new", err, 2'b10);

        // 6: held strobe enqueues once; sine behind a voice-op follows it directly
        @(negedge clk);
        num = 16'hC001; val = 16'h0006; strobe = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            cnt += int'(sineEn);
        end
        strobe = 1'b0;
        repeat (10) begin
            @(negedge clk);
            cnt += int'(sineEn);
        end
        check("t6_held_once", cnt, 1);
        waitVo(8'h50);
        pulse(16'h8040, 16'h7777);
        pulse(16'hC002, 16'h8888);
        voCyc = -100; sineCyc = -200;
        repeat (300) begin
            @(negedge clk);
            if (voEn) voCyc = cyc;
            if (sineEn) begin
                sineCyc = cyc;
                check("t6_sine_data", wData, 16'h8888);
            end
        end
        check("t6_voice_slot_seen", (voCyc >= 0), 1);
        check("t6_sine_follows", sineCyc - voCyc, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
